// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Two-read/one-write register file with pending-write scoreboard
//            and optional same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(NREGS)-1:0]   r_reg0,
    input  logic [$clog2(NREGS)-1:0]   r_reg1,
    output logic [XLEN-1:0]            r_dat0,
    output logic [XLEN-1:0]            r_dat1,
    output logic                       r_busy0,
    output logic                       r_busy1,
    input  logic                       issue,
    input  logic [$clog2(NREGS)-1:0]   issue_reg,
    input  logic                       write,
    input  logic [$clog2(NREGS)-1:0]   w_reg,
    input  logic [XLEN-1:0]            w_dat,
    input  logic                       flush,
    output logic [$clog2(NREGS):0]     pending
);

    localparam int AW     = $clog2(NREGS);
    localparam bit C_ZERO = (ZERO_REG != 0);
    localparam bit C_BYP  = (BYPASS != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      pending_q;
    logic [AW:0]      pending_d;

    logic w_we;
    logic w_ie;
    logic w_inc;
    logic w_dec;

    assign w_we = write & ~(C_ZERO & (w_reg == '0));
    assign w_ie = issue & ~(C_ZERO & (issue_reg == '0));

    // Counter moves only on real bit transitions; an issue landing on the
    // register being written keeps it busy, so that write is not a clear.
    assign w_inc = w_ie & ~busy_q[issue_reg];
    assign w_dec = w_we & busy_q[w_reg] & ~(w_ie & (issue_reg == w_reg));

    always_comb begin
        busy_d    = busy_q;
        pending_d = pending_q;
        if (flush) begin
            busy_d    = '0;
            pending_d = '0;
        end else begin
            if (w_we) busy_d[w_reg]     = 1'b0;
            if (w_ie) busy_d[issue_reg] = 1'b1;
            pending_d = pending_q + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            if (w_we) regs_q[w_reg] <= w_dat;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        r_dat0  = regs_q[r_reg0];
        r_busy0 = busy_q[r_reg0];
        if (C_ZERO && (r_reg0 == '0)) begin
            r_dat0  = '0;
            r_busy0 = 1'b0;
        end else if (C_BYP && w_we && (w_reg == r_reg0)) begin
            r_dat0  = w_dat;
            r_busy0 = 1'b0;
        end
    end

    always_comb begin
        r_dat1  = regs_q[r_reg1];
        r_busy1 = busy_q[r_reg1];
        if (C_ZERO && (r_reg1 == '0)) begin
            r_dat1  = '0;
            r_busy1 = 1'b0;
        end else if (C_BYP && w_we && (w_reg == r_reg1)) begin
            r_dat1  = w_dat;
            r_busy1 = 1'b0;
        end
    end

    assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Self-checking bench for regfile_sb (default build and a
//            16 x 64-bit build without bypass).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  r_reg0, r_reg1, issue_reg, w_reg;
    logic [31:0] r_dat0, r_dat1, w_dat;
    logic        r_busy0, r_busy1, issue, write, flush;
    logic [5:0]  pending;

    logic [3:0]  b_r_reg0, b_r_reg1, b_issue_reg, b_w_reg;
    logic [63:0] b_r_dat0, b_r_dat1, b_w_dat;
    logic        b_r_busy0, b_r_busy1, b_issue, b_write, b_flush;
    logic [4:0]  b_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state for the default build
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .r_reg0(r_reg0), .r_reg1(r_reg1),
        .r_dat0(r_dat0), .r_dat1(r_dat1),
        .r_busy0(r_busy0), .r_busy1(r_busy1),
        .issue(issue), .issue_reg(issue_reg),
        .write(write), .w_reg(w_reg), .w_dat(w_dat),
        .flush(flush), .pending(pending)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(0)) u_dut16 (
        .clk(clk), .rst(rst),
        .r_reg0(b_r_reg0), .r_reg1(b_r_reg1),
        .r_dat0(b_r_dat0), .r_dat1(b_r_dat1),
        .r_busy0(b_r_busy0), .r_busy1(b_r_busy1),
        .issue(b_issue), .issue_reg(b_issue_reg),
        .write(b_write), .w_reg(b_w_reg), .w_dat(b_w_dat),
        .flush(b_flush), .pending(b_pending)
    );

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (write && w_reg != 0) m_regs[w_reg] = w_dat;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (write && w_reg != 0)     m_busy[w_reg]     = 1'b0;
            if (issue && issue_reg != 0) m_busy[issue_reg] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_dat(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (write && w_reg == a) return w_dat;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (write && w_reg == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] exp_pend();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 6'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue = 1'b0; write = 1'b0; flush = 1'b0;
        b_issue = 1'b0; b_write = 1'b0; b_flush = 1'b0;
    endtask

    task automatic test_reset();
        write = 1'b1; w_reg = 5'd5; w_dat = 32'hDEADBEEF;
        issue = 1'b1; issue_reg = 5'd9;
        step();
        idle(); r_reg0 = 5'd5; r_reg1 = 5'd9; #2;
        n_checks++;
        if (r_dat0 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL reset_prewrite: got %h want %h", r_dat0, 32'hDEADBEEF);
        end
        n_checks++;
        if (pending !== 6'd1 || r_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_preissue: pending %0d busy %b want 1 1", pending, r_busy1);
        end
        rst = 1'b1; #1;
        model_reset();
        n_checks++;
        if (r_dat0 !== 32'h0 || r_busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_read: dat %h busy %b want 0 0", r_dat0, r_busy0);
        end
        n_checks++;
        if (pending !== 6'd0 || r_busy1 !== 1'b0 || b_pending !== 5'd0) begin
            n_fail++; $display("FAIL reset_async_pend: pending %0d busy1 %b pend16 %0d want 0", pending, r_busy1, b_pending);
        end
        step();
        rst = 1'b0;
        step(); #1;
        n_checks++;
        if (r_dat0 !== 32'h0 || pending !== 6'd0) begin
            n_fail++; $display("FAIL reset_after: dat %h pending %0d want 0 0", r_dat0, pending);
        end
    endtask

    task automatic test_zero_reg();
        issue = 1'b1; issue_reg = 5'd0; r_reg0 = 5'd0;
        step();
        idle(); write = 1'b1; w_reg = 5'd0; w_dat = 32'h1234; #2;
        n_checks++;
        if (r_dat0 !== 32'h0 || r_busy0 !== 1'b0) begin
            n_fail++; $display("FAIL zero_write_cycle: dat %h busy %b want 0 0", r_dat0, r_busy0);
        end
        step();
        idle(); #2;
        n_checks++;
        if (r_dat0 !== 32'h0 || r_busy0 !== 1'b0 || pending !== 6'd0) begin
            n_fail++; $display("FAIL zero_after: dat %h busy %b pending %0d want 0 0 0", r_dat0, r_busy0, pending);
        end
    endtask

    task automatic test_lifecycle();
        issue = 1'b1; issue_reg = 5'd3; r_reg0 = 5'd3; #2;
        n_checks++;
        if (r_busy0 !== 1'b0) begin
            n_fail++; $display("FAIL life_issue_cycle: busy %b want 0", r_busy0);
        end
        step();
        idle(); #2;
        n_checks++;
        if (r_busy0 !== 1'b1 || pending !== 6'd1) begin
            n_fail++; $display("FAIL life_busy: busy %b pending %0d want 1 1", r_busy0, pending);
        end
        write = 1'b1; w_reg = 5'd3; w_dat = 32'hA5A5A5A5; #2;
        n_checks++;
        if (r_dat0 !== 32'hA5A5A5A5 || r_busy0 !== 1'b0 || pending !== 6'd1) begin
            n_fail++; $display("FAIL life_bypass: dat %h busy %b pending %0d want a5a5a5a5 0 1", r_dat0, r_busy0, pending);
        end
        step();
        idle(); #2;
        n_checks++;
        if (r_dat0 !== 32'hA5A5A5A5 || r_busy0 !== 1'b0 || pending !== 6'd0) begin
            n_fail++; $display("FAIL life_done: dat %h busy %b pending %0d want a5a5a5a5 0 0", r_dat0, r_busy0, pending);
        end
    endtask

    task automatic test_simultaneous();
        issue = 1'b1; issue_reg = 5'd7; write = 1'b1; w_reg = 5'd7; w_dat = 32'h77;
        step();
        idle(); r_reg0 = 5'd7; #2;
        n_checks++;
        if (r_busy0 !== 1'b1 || pending !== 6'd1 || r_dat0 !== 32'h77) begin
            n_fail++; $display("FAIL sim_same: busy %b pending %0d dat %h want 1 1 77", r_busy0, pending, r_dat0);
        end
        issue = 1'b1; issue_reg = 5'd9;
        step();
        issue_reg = 5'd8; write = 1'b1; w_reg = 5'd9; w_dat = 32'h99;
        step();
        idle(); r_reg0 = 5'd8; r_reg1 = 5'd9; #2;
        n_checks++;
        if (pending !== 6'd2 || r_busy0 !== 1'b1 || r_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL sim_diff: pending %0d busy8 %b busy9 %b want 2 1 0", pending, r_busy0, r_busy1);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            write = 1'b1; w_reg = 5'(1 << k); w_dat = 32'hF00D_0000 + 32'(k);
            step();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            issue = 1'b1; issue_reg = 5'(1 << k);
            step();
        end
        idle(); #2;
        n_checks++;
        if (pending !== 6'd3) begin
            n_fail++; $display("FAIL flush_pre: pending %0d want 3", pending);
        end
        flush = 1'b1; issue = 1'b1; issue_reg = 5'd6;
        step();
        idle(); r_reg0 = 5'd6; r_reg1 = 5'd2; #2;
        n_checks++;
        if (pending !== 6'd0 || r_busy0 !== 1'b0 || r_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: pending %0d busy6 %b busy2 %b want 0 0 0", pending, r_busy0, r_busy1);
        end
        for (int k = 0; k < 3; k++) begin
            r_reg0 = 5'(1 << k); #1;
            n_checks++;
            if (r_dat0 !== m_regs[1 << k] || m_regs[1 << k] !== 32'hF00D_0000 + 32'(k)) begin
                n_fail++; $display("FAIL flush_data_r%0d: got %h want %h", 1 << k, r_dat0, 32'hF00D_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] lim;
            lim       = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            issue     = ($urandom_range(0, 2) == 0);
            write     = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            issue_reg = 5'($urandom_range(0, int'(lim)));
            w_reg     = 5'($urandom_range(0, int'(lim)));
            w_dat     = $urandom;
            r_reg0    = 5'($urandom_range(0, int'(lim)));
            r_reg1    = ($urandom_range(0, 3) == 0) ? r_reg0 : 5'($urandom_range(0, int'(lim)));
            #2;
            n_checks++;
            if (r_dat0 !== exp_dat(r_reg0) || r_busy0 !== exp_busy(r_reg0)) begin
                n_fail++; $display("FAIL rand_port0 c%0d r%0d: dat %h busy %b want %h %b", c, r_reg0, r_dat0, r_busy0, exp_dat(r_reg0), exp_busy(r_reg0));
            end
            n_checks++;
            if (r_dat1 !== exp_dat(r_reg1) || r_busy1 !== exp_busy(r_reg1)) begin
                n_fail++; $display("FAIL rand_port1 c%0d r%0d: dat %h busy %b want %h %b", c, r_reg1, r_dat1, r_busy1, exp_dat(r_reg1), exp_busy(r_reg1));
            end
            n_checks++;
            if (pending !== exp_pend()) begin
                n_fail++; $display("FAIL rand_pending c%0d: got %0d want %0d", c, pending, exp_pend());
            end
            step();
        end
        idle();
    endtask

    task automatic test_param();
        b_write = 1'b1; b_w_reg = 4'd15; b_w_dat = 64'h1111_2222_3333_4444;
        step();
        b_w_dat = 64'hFFFF_0000_FFFF_0000; b_r_reg1 = 4'd15; #2;
        n_checks++;
        if (b_r_dat1 !== 64'h1111_2222_3333_4444) begin
            n_fail++; $display("FAIL p16_nobypass: got %h want %h", b_r_dat1, 64'h1111_2222_3333_4444);
        end
        step();
        b_write = 1'b0; #2;
        n_checks++;
        if (b_r_dat1 !== 64'hFFFF_0000_FFFF_0000) begin
            n_fail++; $display("FAIL p16_newval: got %h want %h", b_r_dat1, 64'hFFFF_0000_FFFF_0000);
        end
        for (int k = 0; k < 16; k++) begin
            b_issue = 1'b1; b_issue_reg = 4'(k);
            step();
        end
        b_issue = 1'b1; b_issue_reg = 4'd5;
        step();
        idle(); b_r_reg0 = 4'd0; #2;
        n_checks++;
        if (b_pending !== 5'd15 || b_r_busy0 !== 1'b0 || b_r_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL p16_all_busy: pending %0d busy0 %b busy15 %b want 15 0 1", b_pending, b_r_busy0, b_r_busy1);
        end
        b_write = 1'b1; b_w_reg = 4'd15; b_w_dat = 64'h5; #2;
        n_checks++;
        if (b_r_busy1 !== 1'b1) begin
            n_fail++; $display("FAIL p16_busy_nobypass: got %b want 1", b_r_busy1);
        end
        step();
        idle(); #2;
        n_checks++;
        if (b_pending !== 5'd14 || b_r_busy1 !== 1'b0 || b_r_dat1 !== 64'h5) begin
            n_fail++; $display("FAIL p16_clear: pending %0d busy %b dat %h want 14 0 5", b_pending, b_r_busy1, b_r_dat1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        r_reg0 = '0; r_reg1 = '0; issue_reg = '0; w_reg = '0; w_dat = '0;
        b_r_reg0 = '0; b_r_reg1 = '0; b_issue_reg = '0; b_w_reg = '0; b_w_dat = '0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_zero_reg();
        test_lifecycle();
        test_simultaneous();
        test_flush();
        test_random();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with a per-register pending-write scoreboard and optional write-to-read bypass. It replaces the plain two-read/one-write register file in the core datapath. Decode marks a destination as pending at issue, and writeback clears the mark. Hazard logic reads the busy flags alongside the operand data to decide stalls.

## Interface

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers (power of two, >= 2); AW = $clog2(NREGS).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes, and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and clears the read-side busy flag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all registers, busy bits and the counter.
- r_reg0  input  AW  read port 0 address.
- r_reg1  input  AW  read port 1 address.
- r_dat0  output  XLEN  read port 0 data (combinational).
- r_dat1  output  XLEN  read port 1 data (combinational).
- r_busy0  output  1  register r_reg0 has an outstanding write.
- r_busy1  output  1  register r_reg1 has an outstanding write.
- issue  input  1  mark issue_reg pending at the next edge.
- issue_reg  input  AW  destination being issued.
- write  input  1  write w_dat into w_reg at the next edge and clear its busy bit.
- w_reg  input  AW  write address.
- w_dat  input  XLEN  write data.
- flush  input  1  clear every busy bit at the next edge; register data is untouched.
- pending  output  AW+1  number of busy bits currently set.

## Operation

- State: regs[NREGS] (XLEN each), busy[NREGS] (1 bit each), pending counter (AW+1 bits).
- Write enable: we = write & !(ZERO_REG & w_reg==0).
- Issue enable: ie = issue & !(ZERO_REG & issue_reg==0).
- Data update on edge: if we, then regs[w_reg] <= w_dat.
- Busy update on edge, in priority order:
  - flush: all busy bits <= 0, pending <= 0. Flush overrides any same-cycle issue.
  - Otherwise, ie and we to the same register: busy stays 1. The new issue supersedes the old write.
  - Otherwise, ie sets busy[issue_reg] and we clears busy[w_reg].
- A write to a non-busy register is legal: data is updated and busy stays 0.
- An issue to an already-busy register is legal: busy stays 1 and pending does not change.
- pending equals popcount(busy) at all times. It is maintained incrementally:
  - +1 when a clear bit is set.
  - -1 when a set bit is cleared.
  - Both at once on different registers gives a net change of 0.
- pending never exceeds NREGS, or NREGS-1 when ZERO_REG=1. No wrap is possible.
- Read port n (n = 0, 1):
  - If ZERO_REG and r_regn==0: dat=0, busy=0.
  - Else if BYPASS and we and w_reg==r_regn: dat=w_dat, busy=0.
  - Else: dat=regs[r_regn], busy=busy[r_regn].
- Both read ports may address the same register. Results are identical.

## Timing

- Reads and busy flags are combinational from addresses and state; there is no read latency.
- Write data is visible in regs from the cycle after the edge. With BYPASS=1 it is also visible in the write cycle itself.
- A busy bit asserts in the cycle after issue. A same-cycle read of issue_reg still reports the pre-issue state.
- Reset is asynchronous. While rst=1:
  - all regs are 0, all busy bits are 0, and pending=0;
  - every r_dat and r_busy reads 0, except bypassed values when write is driven. Writes and issues are blocked while rst is high.
- Reset deassertion takes effect at the first rising edge after rst falls.
- Reset mid-operation discards all outstanding pending marks and data. No partial state survives.

## Test plan

- **Reset clear.** Write 0xDEADBEEF to r5, then pulse rst asynchronously between edges -> r_dat0 reads 0 immediately, r_busy0=0, pending=0.
- **Zero register.** With ZERO_REG=1, issue r0, then write r0 with 0x1234 -> r_dat0(r0)=0, r_busy0=0, pending=0.
- **Scoreboard lifecycle.** Issue r3 -> next cycle r_busy0(r3)=1, pending=1. Write r3 with 0xA5A5A5A5 -> in the write cycle r_dat0=0xA5A5A5A5 and r_busy0=0 via bypass. Next cycle busy[3]=0 and pending=0.
- **Simultaneous events.** Issue r7 and write r7 in the same cycle -> busy[7]=1 and pending=1 afterwards. Issue r8 and write r9, with r9 already busy -> pending unchanged, busy[8]=1, busy[9]=0.
- **Flush.** Issue r1, r2 and r4 over three cycles (pending=3). Assert flush together with an issue of r6 -> next cycle all busy bits are 0, pending=0, and r1/r2/r4 data are unchanged.
- **Parameter sweep.** NREGS=16, XLEN=64, BYPASS=0: write r15 with 0xFFFF_0000_FFFF_0000 -> r_dat1 returns the old value in the write cycle and the new value in the next cycle. Issue all 15 nonzero registers -> pending=15.
